min_sec_counter: RTL and testbench
==================================

Name: min_sec_counter

Overview:
- Timebase and seconds/minutes stage of the clock; sits directly upstream of the hour counter.
- Divides the system clock to a 1 Hz tick and counts seconds 0-59 and minutes 0-59.
- Emits a one-cycle `min_carry` pulse on the 59:59 -> 00:00 rollover; the hour counter consumes this pulse as its increment.
- Optional button-driven time adjust.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; prescaler terminal count is CLK_HZ-1 (legal range >= 1).
- PRE_W, max(1,$clog2(CLK_HZ)), prescaler width (derived localparam, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_all_n  in  1  synchronous, active-low reset.
- run_en  in  1  count enable; low freezes prescaler and counters.
- sec  out  6  seconds, 0-59.
- min  out  6  minutes, 0-59.
- sec_tick  out  1  one-cycle pulse per second increment.
- min_carry  out  1  one-cycle pulse on minute wrap 59 -> 0; drives the hour counter.
- adj_min  in  1  (ADJUST_EN only) minute advance button, level, clk-synchronous.
- adj_sec  in  1  (ADJUST_EN only) seconds zero button, level, clk-synchronous.

Behaviour:
- Reset:
  - reset_all_n low at a clk edge sets prescaler, sec, min, sec_tick, min_carry, and the edge-detect registers to 0.
  - Reset overrides every other input, including mid-count and mid-pulse.
- Prescaler:
  - When run_en=1, it counts 0..CLK_HZ-1 and wraps to 0.
  - The internal tick is high in the cycle where the prescaler equals CLK_HZ-1 and run_en=1.
  - When run_en=0, the prescaler holds and tick=0.
  - CLK_HZ=1 gives tick every enabled cycle.
- Tick cycle updates, all registered on the edge ending the tick cycle:
  - sec < 59: sec <= sec+1.
  - sec == 59: sec <= 0, min <= min+1.
  - sec == 59 and min == 59: sec <= 0 and min <= 0.
  - sec_tick <= 1.
  - min_carry <= 1 only on the 59:59 -> 00:00 transition.
- Both pulses are high for exactly one cycle, coincident with the new sec/min values. They are 0 in every other cycle.
- Latency: first tick after reset at cycle CLK_HZ. sec reads 1 from cycle CLK_HZ+1.
- Outputs never leave range 0-59. No intermediate 60 value is ever visible.
- Deasserting run_en mid-count resumes from the held prescaler value; no tick is lost or duplicated.

Optional Feature:
- Macro: ADJUST_EN.
- Defined:
  - adj_min and adj_sec ports exist. Each gets a registered previous-value rising-edge detector.
  - adj_min rise: min <= (min==59) ? 0 : min+1. sec is unchanged. No min_carry is generated, so hours are never touched by adjust.
  - adj_sec rise: sec <= 0 and prescaler <= 0.
  - Both rise in the same cycle: both actions apply.
  - Any adjust edge in a tick cycle suppresses that tick: no count, and sec_tick=0, min_carry=0.
  - Adjust works regardless of run_en.
  - A held button produces one action only.
- Undefined: ports and edge logic are absent; behaviour is pure counting as above.

Decomposition:
- Package clock_pkg:
  - typedef sec_t = logic [5:0]; typedef min_t = logic [5:0].
  - localparams SEC_MAX=59 and MIN_MAX=59.
  - Shared with the hour counter and display stages.
- Sub-module tick_prescaler:
  - Parameter CLK_HZ.
  - Ports clk, reset_all_n, run_en, clr (adjust zeroing, tied 0 without ADJUST_EN), tick.
  - Instanced once.

Test Plan (CLK_HZ=4):
- Reset release, run_en=1 -> sec_tick high only in cycles 4, 8, 12; sec=1,2,3 respectively; min_carry stays 0.
- Run 59*4 cycles from reset -> sec=59, min=0. Next tick -> sec=0, min=1, sec_tick=1, min_carry=0.
- Preload to 59:58 by running 3598 seconds, then two ticks -> 59:59, then 00:00 with min_carry=1 for exactly one cycle.
- run_en=0 for 10 cycles at prescaler=2 -> sec/min frozen, no pulses. Re-enable -> next tick after exactly 1 more cycle.
- Assert reset_all_n=0 in the min_carry pulse cycle -> next cycle all outputs 0; counting restarts with the first tick 4 cycles after release.
- ADJUST_EN: at min=59 pulse adj_min -> min=0, min_carry=0. Hold adj_min 20 cycles -> single increment. adj_sec coincident with a tick -> sec=0, sec_tick=0, next tick 4 cycles later.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the seconds/minutes, hour and display stages.
package clock_pkg;

    typedef logic [5:0] sec_t;
    typedef logic [5:0] min_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic logic [5:0] incWrap(input logic [5:0] value, input logic [5:0] maxValue);
        return (value == maxValue) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset_all_n,
    input  logic run_en,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] TERMINAL = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] r_count;
    logic             w_atTerminal;

    assign w_atTerminal = (r_count == TERMINAL);
    assign tick         = run_en & w_atTerminal;

    // clr wins over run_en so a seconds-zero adjust also restarts the second.
    always_ff @(posedge clk) begin
        if (!reset_all_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (run_en) begin
            r_count <= w_atTerminal ? '0 : r_count + PRE_W'(1);
        end
    end

endmodule

// File: rtl/min_sec_counter.sv
// Seconds/minutes stage with 1 Hz timebase; min_carry feeds the hour counter.
// Define ADJUST_EN to add the adj_min / adj_sec time-adjust buttons.
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_all_n,
    input  logic       run_en,
`ifdef ADJUST_EN
    input  logic       adj_min,
    input  logic       adj_sec,
`endif
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       sec_tick,
    output logic       min_carry
);

    sec_t r_sec;
    min_t r_min;
    logic r_secTick;
    logic r_minCarry;

    logic w_tick;
    logic w_count;
    logic w_clr;
    logic w_adjMinRise;
    logic w_adjSecRise;

`ifdef ADJUST_EN
    logic r_adjMinPrev;
    logic r_adjSecPrev;

    always_ff @(posedge clk) begin
        if (!reset_all_n) begin
            r_adjMinPrev <= 1'b0;
            r_adjSecPrev <= 1'b0;
        end else begin
            r_adjMinPrev <= adj_min;
            r_adjSecPrev <= adj_sec;
        end
    end

    assign w_adjMinRise = adj_min & ~r_adjMinPrev;
    assign w_adjSecRise = adj_sec & ~r_adjSecPrev;
`else
    assign w_adjMinRise = 1'b0;
    assign w_adjSecRise = 1'b0;
`endif

    assign w_clr = w_adjSecRise;

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk        (clk),
        .reset_all_n(reset_all_n),
        .run_en     (run_en),
        .clr        (w_clr),
        .tick       (w_tick)
    );

    // Any adjust edge swallows a coincident tick so adjust never disturbs the hours.
    assign w_count = w_tick & ~(w_adjMinRise | w_adjSecRise);

    always_ff @(posedge clk) begin
        if (!reset_all_n) begin
            r_sec      <= '0;
            r_min      <= '0;
            r_secTick  <= 1'b0;
            r_minCarry <= 1'b0;
        end else begin
            r_secTick  <= w_count;
            r_minCarry <= w_count && (r_sec == SEC_MAX) && (r_min == MIN_MAX);
            if (w_count) begin
                r_sec <= incWrap(r_sec, SEC_MAX);
                if (r_sec == SEC_MAX) begin
                    r_min <= incWrap(r_min, MIN_MAX);
                end
            end
            if (w_adjSecRise) begin
                r_sec <= '0;
            end
            if (w_adjMinRise) begin
                r_min <= incWrap(r_min, MIN_MAX);
            end
        end
    end

    assign sec       = r_sec;
    assign min       = r_min;
    assign sec_tick  = r_secTick;
    assign min_carry = r_minCarry;

endmodule

// File: tb/tb_min_sec_counter.sv
// Self-checking bench for min_sec_counter at CLK_HZ=4 against a total-seconds reference model.
// Build with ADJUST_EN defined to exercise the adjust buttons as well.
module tb_min_sec_counter;

    localparam int CLK_HZ = 4;

    logic       clock;
    logic       rstN;
    logic       runEn;
    logic       adjMin;
    logic       adjSec;
    logic [5:0] sec;
    logic [5:0] min;
    logic       secTick;
    logic       minCarry;

    int testCount;
    int failCount;

    // Reference state: elapsed seconds of the hour plus enabled cycles into the current second.
    int phase;
    int total;
    bit expTick;
    bit expCarry;
    bit prevAdjMin;
    bit prevAdjSec;

    min_sec_counter #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clk        (clock),
        .reset_all_n(rstN),
        .run_en     (runEn),
`ifdef ADJUST_EN
        .adj_min    (adjMin),
        .adj_sec    (adjSec),
`endif
        .sec        (sec),
        .min        (min),
        .sec_tick   (secTick),
        .min_carry  (minCarry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge();
        bit riseMin;
        bit riseSec;
        bit tickNow;
        bit eff;
        int m;
        if (!rstN) begin
            phase = 0; total = 0; expTick = 0; expCarry = 0;
            prevAdjMin = 0; prevAdjSec = 0;
        end else begin
`ifdef ADJUST_EN
            riseMin = adjMin && !prevAdjMin;
            riseSec = adjSec && !prevAdjSec;
`else
            riseMin = 0;
            riseSec = 0;
`endif
            tickNow  = runEn && (phase == CLK_HZ - 1);
            eff      = tickNow && !(riseMin || riseSec);
            expTick  = eff;
            expCarry = eff && (total == 3599);
            if (runEn) phase = (phase + 1) % CLK_HZ;
            if (riseSec) phase = 0;
            if (eff) total = (total + 1) % 3600;
            if (riseSec) total = total - (total % 60);
            if (riseMin) begin
                m = ((total / 60) + 1) % 60;
                total = m * 60 + (total % 60);
            end
            prevAdjMin = adjMin;
            prevAdjSec = adjSec;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic run, input logic am, input logic as,
                                 input int n);
        for (int i = 0; i < n; i++) begin
            rstN = r; runEn = run; adjMin = am; adjSec = as;
            @(posedge clock);
            modelEdge();
            #1;
            checkOutput("sec",       int'(sec),      total % 60);
            checkOutput("min",       int'(min),      total / 60);
            checkOutput("sec_tick",  int'(secTick),  int'(expTick));
            checkOutput("min_carry", int'(minCarry), int'(expCarry));
        end
    endtask

    initial begin
        int guard;
        testCount = 0; failCount = 0;
        phase = 0; total = 0; expTick = 0; expCarry = 0;
        prevAdjMin = 0; prevAdjSec = 0;
        rstN = 0; runEn = 0; adjMin = 0; adjSec = 0;

        applyStimulus(0, 1, 0, 0, 3);
        checkOutput("reset_sec", int'(sec), 0);
        checkOutput("reset_carry", int'(minCarry), 0);

        applyStimulus(1, 1, 0, 0, 3);
        checkOutput("pre_first_tick", int'(secTick), 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("tick_cycle4", int'(secTick), 1);
        checkOutput("sec_is_1", int'(sec), 1);
        applyStimulus(1, 1, 0, 0, 4);
        checkOutput("sec_is_2", int'(sec), 2);
        applyStimulus(1, 1, 0, 0, 4);
        checkOutput("sec_is_3", int'(sec), 3);
        checkOutput("no_carry_3", int'(minCarry), 0);

        applyStimulus(1, 1, 0, 0, 59 * 4 - 12);
        checkOutput("sec_59", int'(sec), 59);
        checkOutput("min_0", int'(min), 0);
        applyStimulus(1, 1, 0, 0, 4);
        checkOutput("wrap_sec", int'(sec), 0);
        checkOutput("wrap_min", int'(min), 1);
        checkOutput("wrap_tick", int'(secTick), 1);
        checkOutput("wrap_nocarry", int'(minCarry), 0);

        applyStimulus(1, 1, 0, 0, (3598 - 60) * 4);
        checkOutput("pre_sec_58", int'(sec), 58);
        checkOutput("pre_min_59", int'(min), 59);
        applyStimulus(1, 1, 0, 0, 4);
        checkOutput("sec_5959", int'(sec), 59);
        applyStimulus(1, 1, 0, 0, 4);
        checkOutput("roll_sec", int'(sec), 0);
        checkOutput("roll_min", int'(min), 0);
        checkOutput("roll_carry", int'(minCarry), 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("carry_one_cycle", int'(minCarry), 0);

        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 10);
        checkOutput("frozen_sec", int'(sec), 0);
        checkOutput("frozen_tick", int'(secTick), 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("resume_no_tick", int'(secTick), 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("resume_tick", int'(secTick), 1);
        checkOutput("resume_sec", int'(sec), 1);

        guard = 0;
        while (!expCarry && guard < 15000) begin
            applyStimulus(1, 1, 0, 0, 1);
            guard++;
        end
        checkOutput("carry_reached", int'(minCarry), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("rst_pulse_carry", int'(minCarry), 0);
        checkOutput("rst_pulse_min", int'(min), 0);
        applyStimulus(1, 1, 0, 0, 3);
        checkOutput("rst_restart_wait", int'(secTick), 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("rst_restart_tick", int'(secTick), 1);

`ifdef ADJUST_EN
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 59; k++) begin
            applyStimulus(1, 0, 1, 0, 1);
            applyStimulus(1, 0, 0, 0, 1);
        end
        checkOutput("adj_min_59", int'(min), 59);
        applyStimulus(1, 0, 1, 0, 1);
        checkOutput("adj_min_wrap", int'(min), 0);
        checkOutput("adj_no_carry", int'(minCarry), 0);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 20);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("adj_hold_once", int'(min), 1);

        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 15);
        applyStimulus(1, 1, 0, 1, 1);
        checkOutput("adj_sec_zero", int'(sec), 0);
        checkOutput("adj_sec_notick", int'(secTick), 0);
        applyStimulus(1, 1, 0, 0, 3);
        checkOutput("adj_sec_wait", int'(secTick), 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("adj_sec_tick", int'(secTick), 1);
`endif

        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                          1);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
